// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the traffic phase scheduler and its environment:
// timing enable, queue sensors and emergency requests in, light field and status out.
interface traffic_phase_scheduler_if;
  logic        tick;
  logic [2:0]  level_a;
  logic [2:0]  level_b;
  logic [2:0]  level_c;
  logic [2:0]  level_d;
  logic [3:0]  emg;
  logic [11:0] lights;
  logic [1:0]  grant;
  logic [2:0]  phase;
  logic        preempt_active;

  modport master (
    output tick, level_a, level_b, level_c, level_d, emg,
    input  lights, grant, phase, preempt_active
  );

  modport slave (
    input  tick, level_a, level_b, level_c, level_d, emg,
    output lights, grant, phase, preempt_active
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Tick-timed green/yellow/all-red scheduler for a four-road intersection with
// sensor-weighted round-robin arbitration and emergency preemption.
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 32,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned TW        = 6
) (
  input logic                      clock,
  input logic                      clear,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StGreen    = 3'd1,
    StYellow   = 3'd2,
    StAllRed   = 3'd3,
    StEmgGreen = 3'd4
  } state_e;

  localparam logic [TW:0] MinG  = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0] MaxG  = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0] YelT  = (TW+1)'(YELLOW_T);
  localparam logic [TW:0] ArT   = (TW+1)'(ALLRED_T);
  localparam logic [11:0] AllRed = 12'b100100100100;

  state_e        r_state, w_state_d;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_grant, w_grant_d;
  logic [1:0]    r_rr_ptr, w_rr_d;
  logic [1:0]    r_excl, w_excl_d;
  logic [11:0]   r_lights, w_lights_d;
  logic          r_preempt, w_preempt_d;

  logic [2:0]    w_lvl [4];
  logic [3:0]    w_dem, w_cand;
  logic [1:0]    w_win, w_emg_road;
  logic          w_emg_any, w_own_emg, w_other_dem, w_other_higher;
  logic [TW:0]   w_t;

  assign w_lvl[0]  = bus.level_a;
  assign w_lvl[1]  = bus.level_b;
  assign w_lvl[2]  = bus.level_c;
  assign w_lvl[3]  = bus.level_d;
  assign w_emg_any = |bus.emg;
  // emg bit 3 belongs to road 0, so the road's own bit is at index ~road
  assign w_own_emg = bus.emg[~r_grant];
  assign w_t       = {1'b0, r_timer} + 1'b1;

  always_comb begin
    if (bus.emg[3])      w_emg_road = 2'd0;
    else if (bus.emg[2]) w_emg_road = 2'd1;
    else if (bus.emg[1]) w_emg_road = 2'd2;
    else                 w_emg_road = 2'd3;
  end

  // Winner: highest level; strict compare keeps the earliest road in scan order.
  always_comb begin
    logic [1:0] idx;
    logic [2:0] best;
    logic       found;
    for (int i = 0; i < 4; i++) w_dem[i] = |w_lvl[i];
    w_cand = w_dem;
    if (r_state == StAllRed && (w_dem & ~(4'b0001 << r_excl)) != 4'b0000) begin
      w_cand[r_excl] = 1'b0;
    end
    found = 1'b0;
    best  = 3'd0;
    w_win = r_rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = r_rr_ptr + 2'(k);
      if (w_cand[idx] && (!found || w_lvl[idx] > best)) begin
        found = 1'b1;
        best  = w_lvl[idx];
        w_win = idx;
      end
    end
  end

  always_comb begin
    w_other_dem    = 1'b0;
    w_other_higher = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != r_grant) begin
        w_other_dem    = w_other_dem | w_dem[i];
        w_other_higher = w_other_higher | (w_lvl[i] > w_lvl[r_grant]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_grant   <= 2'd0;
      r_rr_ptr  <= 2'd0;
      r_excl    <= 2'd0;
      r_lights  <= AllRed;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_grant   <= w_grant_d;
      r_rr_ptr  <= w_rr_d;
      r_excl    <= w_excl_d;
      r_lights  <= w_lights_d;
      r_preempt <= w_preempt_d;
      if (bus.tick) begin
        if (w_state_d != r_state) r_timer <= '0;
        else if (w_t[TW])         r_timer <= '1;
        else                      r_timer <= w_t[TW-1:0];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_rr_d    = r_rr_ptr;
    w_excl_d  = r_excl;
    if (bus.tick) begin
      unique case (r_state)
        StIdle: begin
          if (w_emg_any) begin
            w_state_d = StEmgGreen;
            w_grant_d = w_emg_road;
          end else if (|w_dem) begin
            w_state_d = StGreen;
            w_grant_d = w_win;
          end
        end
        StGreen: begin
          if (w_own_emg) begin
            w_state_d = StEmgGreen;
          end else if (w_emg_any) begin
            w_state_d = StYellow;
          end else if (w_t >= MinG && (w_lvl[r_grant] == 3'd0 || w_other_higher)) begin
            w_state_d = StYellow;
          end else if (w_t >= MaxG && w_other_dem) begin
            w_state_d = StYellow;
          end
        end
        StYellow: begin
          if (w_t == YelT) begin
            w_state_d = StAllRed;
            w_rr_d    = r_grant + 2'd1;
            w_excl_d  = r_grant;
          end
        end
        StAllRed: begin
          if (w_t == ArT) begin
            if (w_emg_any) begin
              w_state_d = StEmgGreen;
              w_grant_d = w_emg_road;
            end else if (|w_dem) begin
              w_state_d = StGreen;
              w_grant_d = w_win;
            end else begin
              w_state_d = StIdle;
            end
          end
        end
        StEmgGreen: begin
          if (!w_own_emg) w_state_d = StYellow;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    logic [2:0] sig;
    unique case (w_state_d)
      StGreen, StEmgGreen: sig = 3'b001;
      StYellow:            sig = 3'b010;
      default:             sig = 3'b100;
    endcase
    w_lights_d = AllRed;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == w_grant_d) w_lights_d[(3-i)*3 +: 3] = sig;
    end
    w_preempt_d = (w_state_d == StEmgGreen);
  end

  assign bus.lights         = r_lights;
  assign bus.grant          = r_grant;
  assign bus.phase          = r_state;
  assign bus.preempt_active = r_preempt;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: reset, single demand, max green,
// round-robin, preemption and own-road emergency, with a one-non-red-road monitor.
module tb_traffic_phase_scheduler;
  logic clock;
  logic clear;
  int   total;
  int   bad;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tick pulse followed by three idle cycles; outputs are stable on return.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      @(posedge clock); #1;
      bus.tick = 1'b0;
      repeat (3) @(posedge clock);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  task automatic set_lvl(input int road, input logic [2:0] v);
    case (road)
      0: bus.level_a = v;
      1: bus.level_b = v;
      2: bus.level_c = v;
      default: bus.level_d = v;
    endcase
  endtask

  always @(negedge clock) begin
    int nonred;
    logic [11:0] l;
    l = bus.lights;
    nonred = 0;
    for (int i = 0; i < 4; i++) if (l[i*3 +: 3] != 3'b100) nonred++;
    if (!clear) begin
      total++;
      assert (nonred <= 1) else begin
        bad++;
        $error("FAIL safety observed=%0d nonred expected<=1 lights=%b", nonred, l);
      end
    end
  end

  initial begin
    logic [1:0] rr_exp [5];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
    total = 0;
    bad = 0;
    clear = 1'b1;
    bus.tick = 1'b0;
    bus.level_a = 3'd0; bus.level_b = 3'd0; bus.level_c = 3'd0; bus.level_d = 3'd0;
    bus.emg = 4'b0000;
    do_clear();

    // Reset during an A green
    bus.level_a = 3'd1;
    ticks(1);
    chk("a_green_lights", bus.lights, 12'b001100100100);
    chk("a_green_phase", 12'(bus.phase), 12'd1);
    do_clear();
    chk("rst_lights", bus.lights, 12'b100100100100);
    chk("rst_phase", 12'(bus.phase), 12'd0);
    chk("rst_preempt", 12'(bus.preempt_active), 12'd0);
    chk("rst_grant", 12'(bus.grant), 12'd0);

    // Single demand on B
    bus.level_a = 3'd0;
    bus.level_b = 3'd1;
    ticks(1);
    chk("b_green_lights", bus.lights, 12'b100001100100);
    chk("b_green_grant", 12'(bus.grant), 12'd1);
    bus.level_b = 3'd0;
    ticks(7);
    chk("b_hold_min", 12'(bus.phase), 12'd1);
    ticks(1);
    chk("b_yellow", bus.lights, 12'b100010100100);
    ticks(3);
    chk("b_yellow_hold", bus.lights, 12'b100010100100);
    ticks(1);
    chk("b_allred_lights", bus.lights, 12'b100100100100);
    chk("b_allred_phase", 12'(bus.phase), 12'd3);
    ticks(1);
    chk("b_allred_hold", 12'(bus.phase), 12'd3);
    ticks(1);
    chk("b_idle", 12'(bus.phase), 12'd0);

    // Max green with C waiting
    do_clear();
    bus.level_a = 3'd7;
    bus.level_c = 3'd1;
    ticks(1);
    chk("max_a_green", bus.lights, 12'b001100100100);
    ticks(31);
    chk("max_hold31", 12'(bus.phase), 12'd1);
    ticks(1);
    chk("max_yellow", bus.lights, 12'b010100100100);
    ticks(4);
    chk("max_allred", 12'(bus.phase), 12'd3);
    ticks(2);
    chk("max_c_green", bus.lights, 12'b100100001100);
    chk("max_c_grant", 12'(bus.grant), 12'd2);

    // Round-robin among equal levels
    do_clear();
    bus.level_a = 3'd3; bus.level_b = 3'd3; bus.level_c = 3'd3; bus.level_d = 3'd3;
    ticks(1);
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("rr_grant%0d", r), 12'(bus.grant), 12'(rr_exp[r]));
      chk($sformatf("rr_phase%0d", r), 12'(bus.phase), 12'd1);
      if (r < 4) begin
        set_lvl(r, 3'd0);
        ticks(8);
        chk($sformatf("rr_yellow%0d", r), 12'(bus.phase), 12'd2);
        set_lvl(r, 3'd3);
        ticks(6);
      end
    end

    // Preemption by C during A green
    do_clear();
    bus.level_b = 3'd0; bus.level_c = 3'd0; bus.level_d = 3'd0;
    bus.level_a = 3'd1;
    ticks(4);
    bus.emg = 4'b0010;
    ticks(1);
    chk("pre_a_yellow", bus.lights, 12'b010100100100);
    ticks(4);
    chk("pre_allred", bus.lights, 12'b100100100100);
    ticks(2);
    chk("pre_c_lights", bus.lights, 12'b100100001100);
    chk("pre_active", 12'(bus.preempt_active), 12'd1);
    chk("pre_phase", 12'(bus.phase), 12'd4);
    chk("pre_grant", 12'(bus.grant), 12'd2);
    bus.emg = 4'b0000;
    ticks(1);
    chk("pre_c_yellow", bus.lights, 12'b100100010100);
    chk("pre_inactive", 12'(bus.preempt_active), 12'd0);
    ticks(4);
    chk("pre_end_allred", 12'(bus.phase), 12'd3);

    // Own-road emergency on A
    do_clear();
    bus.level_a = 3'd1;
    ticks(2);
    bus.emg = 4'b1000;
    ticks(1);
    chk("own_phase", 12'(bus.phase), 12'd4);
    chk("own_lights", bus.lights, 12'b001100100100);
    chk("own_preempt", 12'(bus.preempt_active), 12'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Timed phase scheduler that shares one four-road intersection between its roads.
- Grants green to one road at a time. Winner is the road with the highest sensor level; ties are broken round-robin.
- Enforces minimum green, maximum green, yellow and all-red clearance intervals, counted in `tick` pulses.
- Emergency (sound-sensor) requests preempt normal scheduling.
- Drives the 12-bit light field used across the traffic design: road A in bits [11:9], B [8:6], C [5:3], D [2:0]. Per road, 100 = red, 010 = yellow, 001 = green.

Parameters:
- MIN_GREEN, 8, minimum green length in ticks (normal phases).
- MAX_GREEN, 32, maximum green length in ticks while another road demands.
- YELLOW_T, 4, yellow length in ticks.
- ALLRED_T, 2, all-red clearance length in ticks.
- TW, 6, timer width.
- Constraints: 1 <= MIN_GREEN <= MAX_GREEN < 2^TW; YELLOW_T, ALLRED_T >= 1.

Ports:
- clock  input  1  system clock; one clock only.
- clear  input  1  reset, synchronous, active-high.
- tick  input  1  one-cycle timing enable; all timing and FSM moves happen only on tick cycles.
- level_a, level_b, level_c, level_d  input  3 each  queue sensors {x3,x2,x1}, compared as unsigned; nonzero = demand.
- emg  input  4  emergency request; emg[3]=A, emg[2]=B, emg[1]=C, emg[0]=D.
- lights  output  12  registered light field.
- grant  output  2  current or last green road (0=A, 1=B, 2=C, 3=D).
- phase  output  3  state code: IDLE=0, GREEN=1, YELLOW=2, ALLRED=3, EMG_GREEN=4.
- preempt_active  output  1  high while in EMG_GREEN.

Behaviour:
- Reset values: phase=IDLE, lights=12'b100100100100, grant=0, timer=0, rr_ptr=0, preempt_active=0.
- clear wins over everything, from any state, tick irrelevant. No yellow is issued on clear.
- Outputs are registered and update on the clock edge that ends the deciding tick cycle.
- Tick counting: on a tick cycle, t = timer+1. If the state exits, timer <= 0. Otherwise timer <= t, saturating at 2^TW-1. On non-tick cycles timer, state and outputs hold.
- Winner selection (combinational):
  - Candidates are roads with level != 0, excluding the `excl` road whenever any other road demands.
  - Highest level wins.
  - Ties go to the first candidate scanning from rr_ptr upward, mod 4.
- Emergency road: highest-priority set bit of emg, with A > B > C > D.
- IDLE (all red), on tick:
  - any emg set -> EMG_GREEN on the emergency road;
  - else any demand -> GREEN on the winner (excl = none);
  - else stay in IDLE.
- GREEN on road g, on tick, checked in this order:
  1. emg[g] set -> EMG_GREEN, same road, lights unchanged.
  2. Any other emg bit set -> YELLOW, even if MIN_GREEN has not been reached.
  3. t >= MIN_GREEN and (level_g == 0, or another road's level > level_g) -> YELLOW.
  4. t >= MAX_GREEN and any other road demands -> YELLOW.
  5. Otherwise stay in GREEN. Green is unbounded while no other road demands.
- YELLOW: road g shows 010, others 100. Exit to ALLRED when t == YELLOW_T.
- Any exit from YELLOW sets rr_ptr <= g+1 mod 4 and excl <= g.
- ALLRED: all 100. When t == ALLRED_T:
  - any emg set -> EMG_GREEN;
  - else any demand -> GREEN on the winner;
  - else -> IDLE.
- EMG_GREEN on road e: e green, preempt_active=1, grant=e. Other emg bits are ignored while emg[e] stays high. When emg[e] is low on a tick -> YELLOW on e. There is no minimum or maximum timing in EMG_GREEN.
- Safety invariant: at most one road is non-red at any time. Two roads are never non-red in the same cycle.

Test Plan:
- Reset: clear held 2 cycles during an A green -> lights=12'b100100100100, phase=0, preempt_active=0 on the next edge.
- Single demand (tick every 4 cycles):
  - level_b=001 from IDLE -> first tick gives lights=100001100100, grant=1.
  - level_b=0 before tick 8 -> green until tick 8, then 100010100100 for 4 ticks, then all red for 2 ticks, then IDLE.
- Max green: level_a=111, level_c=001 held -> A green for 32 ticks, yellow, all-red, then C green (A is excluded) with lights=100100001100.
- Round-robin: all levels 011 from reset, each level dropped at MIN_GREEN -> grant sequence A, B, C, D, A.
- Preemption:
  - During A green at t=3, emg=0010 (C) -> next tick A yellow, then all-red, then lights=100100001100 with preempt_active=1.
  - Drop emg -> C yellow, then all-red.
- Own-road emergency: A green and emg[3] rises -> phase=4 with no yellow, lights stay 001100100100.
